// File: rtl/sw_hw_handshake_pkg.sv
// Shared types and default constants for the sw/hw handshake block.
// The optional timeout is built only when HS_TIMEOUT_EN is defined.
package sw_hw_handshake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int unsigned DEF_CNT_W          = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/sw_hw_handshake_sat_counter.sv
// Saturating up-counter with synchronous clear and enable;
// holds its value when neither clear nor enable is active.
module hs_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sw_hw_handshake.sv
// 4-phase sw_req/hw_ack handshake around a job engine, with job timing.
// Define HS_TIMEOUT_EN to add the BUSY timeout with forced abort.
module sw_hw_handshake
  import sw_hw_handshake_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sw_req,
  input  logic             hw_done,
  output logic             hw_start,
  output logic             hw_abort,
  output logic             hw_ack,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count
);

  state_t state, next;
  logic   abort_d;
  logic   err_d;
  logic   cnt_clr;
  logic   cnt_en;

`ifdef HS_TIMEOUT_EN
  logic at_limit;
  assign at_limit =
    (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    next    = state;
    abort_d = 1'b0;
    err_d   = err;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sw_req) begin
          next    = START;
          cnt_clr = 1'b1;
          err_d   = 1'b0;
        end
      end
      START: begin
        if (!sw_req) begin
          next    = IDLE;
          abort_d = 1'b1;
        end else begin
          next = BUSY;
        end
      end
      BUSY: begin
        // done beats both a software drop and the timeout
        if (hw_done) begin
          next   = ACK;
          cnt_en = 1'b1;
        end else if (!sw_req) begin
          next    = IDLE;
          abort_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
`ifdef HS_TIMEOUT_EN
          if (at_limit) begin
            next    = ACK;
            abort_d = 1'b1;
            err_d   = 1'b1;
          end
`endif
        end
      end
      ACK: begin
        if (!sw_req) begin
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hw_start <= 1'b0;
      hw_abort <= 1'b0;
      hw_ack   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= next;
      hw_start <= (next == START);
      hw_abort <= abort_d;
      hw_ack   <= (next == ACK);
      busy     <= (next == START) || (next == BUSY);
    end
  end

`ifdef HS_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else begin
      err <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

  hs_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .count   (cycle_count)
  );

endmodule

// File: tb/tb_sw_hw_handshake.sv
// Directed self-checking bench for sw_hw_handshake (CNT_W=4,
// TIMEOUT_CYCLES=8); timeout scenario runs only with HS_TIMEOUT_EN.
module tb_sw_hw_handshake;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TO_CYC = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             sw_req = 1'b0;
  logic             hw_done = 1'b0;
  logic             hw_start;
  logic             hw_abort;
  logic             hw_ack;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] cycle_count;

  int checks = 0;
  int errors = 0;

  sw_hw_handshake #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_req      (sw_req),
    .hw_done     (hw_done),
    .hw_start    (hw_start),
    .hw_abort    (hw_abort),
    .hw_ack      (hw_ack),
    .busy        (busy),
    .err         (err),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // go from IDLE through START into the first BUSY cycle
  task automatic launch();
    sw_req = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sw_req = 1'b0;
    hw_done = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick();
    chk("rst_outs",
        {hw_start, hw_abort, hw_ack, busy, err}, 0);
    chk("rst_cnt", cycle_count, 0);
  endtask

  task automatic test_normal();
    hw_done = 1'b1;
    tick();
    chk("idle_done_ignored", {hw_ack, busy}, 0);
    hw_done = 1'b0;
    sw_req = 1'b1;
    tick();
    chk("norm_start", hw_start, 1);
    chk("norm_start_busy", busy, 1);
    chk("norm_start_cnt", cycle_count, 0);
    tick();
    chk("norm_start_pulse", hw_start, 0);
    tick(6);
    chk("norm_busy_cnt", cycle_count, 6);
    chk("norm_busy_ack", hw_ack, 0);
    hw_done = 1'b1;
    tick();
    hw_done = 1'b0;
    chk("norm_ack", hw_ack, 1);
    chk("norm_ack_busy", busy, 0);
    chk("norm_cnt", cycle_count, 7);
    tick(3);
    chk("norm_ack_hold", hw_ack, 1);
    chk("norm_cnt_frozen", cycle_count, 7);
    sw_req = 1'b0;
    tick();
    chk("norm_ack_fall", hw_ack, 0);
  endtask

  task automatic test_abort();
    launch();
    tick(4);
    chk("abort_pre_cnt", cycle_count, 4);
    sw_req = 1'b0;
    tick();
    chk("abort_pulse", hw_abort, 1);
    chk("abort_no_ack", {hw_ack, busy}, 0);
    chk("abort_cnt", cycle_count, 4);
    tick();
    chk("abort_pulse_end", hw_abort, 0);
    chk("abort_idle", {hw_ack, busy, hw_start}, 0);
  endtask

  task automatic test_start_abort();
    sw_req = 1'b1;
    tick();
    chk("sabort_start", hw_start, 1);
    sw_req = 1'b0;
    tick();
    chk("sabort_pulse", hw_abort, 1);
    chk("sabort_busy", busy, 0);
    tick();
    chk("sabort_end", {hw_abort, hw_start}, 0);
  endtask

  task automatic test_simultaneous();
    launch();
    tick(2);
    sw_req = 1'b0;
    hw_done = 1'b1;
    tick();
    hw_done = 1'b0;
    chk("sim_ack", hw_ack, 1);
    chk("sim_no_abort", hw_abort, 0);
    chk("sim_cnt", cycle_count, 3);
    tick();
    chk("sim_ack_fall", hw_ack, 0);
    chk("sim_no_abort2", hw_abort, 0);
  endtask

  task automatic test_saturation();
    launch();
    tick(19);
    chk("sat_pre", cycle_count, 15);
    hw_done = 1'b1;
    tick();
    hw_done = 1'b0;
    chk("sat_ack", hw_ack, 1);
    chk("sat_cnt", cycle_count, 15);
    sw_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    launch();
    tick(7);
    chk("to_pre_abort", hw_abort, 0);
    chk("to_pre_cnt", cycle_count, 7);
    tick();
    chk("to_abort", hw_abort, 1);
    chk("to_err", err, 1);
    chk("to_ack", hw_ack, 1);
    chk("to_busy", busy, 0);
    tick();
    chk("to_abort_end", hw_abort, 0);
    sw_req = 1'b0;
    tick();
    chk("to_ack_fall", hw_ack, 0);
    chk("to_err_hold", err, 1);
    sw_req = 1'b1;
    tick();
    chk("to_err_clr", err, 0);
    chk("to_restart", hw_start, 1);
    sw_req = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid_busy();
    launch();
    tick(3);
    chk("rmb_busy", busy, 1);
    reset_n = 1'b0;
    sw_req = 1'b0;
    #1;
    chk("rmb_async",
        {hw_start, hw_abort, hw_ack, busy, err}, 0);
    chk("rmb_cnt", cycle_count, 0);
    tick();
    reset_n = 1'b1;
    hw_done = 1'b1;
    tick(2);
    chk("rmb_stray_done", {hw_ack, busy, hw_abort}, 0);
    hw_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_abort();
    test_start_abort();
    test_simultaneous();
`ifdef HS_TIMEOUT_EN
    test_timeout();
`else
    test_saturation();
`endif
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
